// File: rtl/cnn_mem_pkg.sv
// Shared definitions for the CNN line-memory datapath.
//   - Default word width, line length and address width for the 1-D line memory.
//   - Write-side sequencer state encoding (FILL, DRAIN, PRESENT, DUMP).
package cnn_mem_pkg;

  localparam int DW_DEF       = 16;
  localparam int MEM_SIZE_DEF = 10;
  localparam int MEM_ADDR_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    DRAIN   = 2'd1,
    PRESENT = 2'd2,
    DUMP    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mod_counter.sv
// Wrapping up-counter with terminal flag.
//   Counts 0..LAST on each enabled cycle, then wraps to 0; never exceeds LAST.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   asynchronous, active-low
//   en_i    in   advance the count this cycle
//   cnt_o   out  current count
//   last_o  out  count is at LAST (next enabled cycle wraps to 0)
module mod_counter #(
  parameter int W    = 4,
  parameter int LAST = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         last_o
);

  localparam logic [W-1:0] LAST_V = W'(LAST);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign last_o = (cnt_q == LAST_V);
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = last_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/line_mem_loader.sv
// Write-side sequencer for the 1-D line memory feeding the conv stage.
//   Fills MEM_SIZE consecutive addresses from a valid/ready pixel stream, presents
//   the full line via the memory wide-read enable until the conv stage acks, then
//   refills. When idle at the start of a line it can also dump the stored line
//   word-by-word over the memory chip-read port.
// Ports:
//   clk, reset        clock (rising) / asynchronous active-low reset
//   s_data/s_valid    input pixel stream, s_ready back-pressure (combinational)
//   mem_data_in       write data to line memory (registered)
//   mem_in_add        write address (registered) or chip-read address during a dump
//   mem_wr_en         write strobe, one cycle after the accept
//   mem_rd_en         wide-read enable while the line is presented
//   mem_chiprd_en     single-word read enable during a dump
//   mem_chip_data     single-word read data from memory (combinational from mem_in_add)
//   line_valid        full line on the wide bus; line_ack consumes it
//   dump_req          request a dump; honoured only in FILL with no partial line
//   dump_data/valid   dumped words, one pulse per word, no gaps
//   busy              not idle at the start of a line
//   line_cnt          lines acknowledged since reset, wraps
module line_mem_loader
  import cnn_mem_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int MEM_SIZE = MEM_SIZE_DEF,
  parameter int MEM_ADDR = MEM_ADDR_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic signed [DW-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic signed [DW-1:0] mem_data_in,
  output logic [MEM_ADDR-1:0]  mem_in_add,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic                 mem_chiprd_en,
  input  logic signed [DW-1:0] mem_chip_data,
  output logic                 line_valid,
  input  logic                 line_ack,
  input  logic                 dump_req,
  output logic signed [DW-1:0] dump_data,
  output logic                 dump_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     line_cnt
);

  loader_state_e state_q, state_d;

  logic [MEM_ADDR-1:0] wr_ptr;
  logic                wr_last;
  logic [MEM_ADDR-1:0] dump_idx;
  logic                dump_last;

  logic                 accept;
  logic                 dump_go;
  logic                 in_dump;

  logic                 wr_en_q, wr_en_d;
  logic [MEM_ADDR-1:0]  add_q, add_d;
  logic signed [DW-1:0] data_q, data_d;
  logic                 lv_q, lv_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 dv_q, dv_d;
  logic signed [DW-1:0] dd_q, dd_d;

  // A pending dump request blocks the stream even mid-line; it only starts a
  // dump once no partial line is held.
  assign s_ready = (state_q == FILL) && !dump_req;
  assign accept  = s_valid && s_ready;
  assign dump_go = (state_q == FILL) && dump_req && (wr_ptr == '0);
  assign in_dump = (state_q == DUMP);

  mod_counter #(.W(MEM_ADDR), .LAST(MEM_SIZE - 1)) u_wr_ptr (
    .clk    (clk),
    .reset  (reset),
    .en_i   (accept),
    .cnt_o  (wr_ptr),
    .last_o (wr_last)
  );

  mod_counter #(.W(MEM_ADDR), .LAST(MEM_SIZE - 1)) u_dump_idx (
    .clk    (clk),
    .reset  (reset),
    .en_i   (in_dump),
    .cnt_o  (dump_idx),
    .last_o (dump_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (dump_go) begin
          state_d = DUMP;
        end else if (accept && wr_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN:   state_d = PRESENT;
      PRESENT: if (line_ack) state_d = FILL;
      DUMP:    if (dump_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    wr_en_d = accept;
    add_d   = accept ? wr_ptr : add_q;
    data_d  = accept ? s_data : data_q;
    // Rises on leaving DRAIN so the line is only shown after its last write lands.
    lv_d    = (state_q == DRAIN) || ((state_q == PRESENT) && !line_ack);
    cnt_d   = ((state_q == PRESENT) && line_ack) ? cnt_q + 1'b1 : cnt_q;
    dv_d    = in_dump;
    dd_d    = in_dump ? mem_chip_data : dd_q;
  end

  // ---- register stage: state and registered outputs ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      wr_en_q <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      lv_q    <= 1'b0;
      cnt_q   <= '0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      add_q   <= add_d;
      data_q  <= data_d;
      lv_q    <= lv_d;
      cnt_q   <= cnt_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
    end
  end

  // The chip-read port shares the address bus; during a dump the live index
  // drives it so read data is captured one cycle later.
  assign mem_in_add    = in_dump ? dump_idx : add_q;
  assign mem_chiprd_en = in_dump;
  assign mem_data_in   = data_q;
  assign mem_wr_en     = wr_en_q;
  assign mem_rd_en     = lv_q;
  assign line_valid    = lv_q;
  assign dump_data     = dd_q;
  assign dump_valid    = dv_q;
  assign line_cnt      = cnt_q;
  assign busy          = (state_q != FILL) || (wr_ptr != '0);

endmodule

// File: tb/tb_line_mem_loader.sv
module tb_line_mem_loader;

  localparam int DW = 16;
  localparam int MS = 10;
  localparam int AW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic signed [DW-1:0] s_data = '0;
  logic s_valid = 1'b0;
  logic line_ack = 1'b0;
  logic dump_req = 1'b0;

  logic s_ready;
  logic signed [DW-1:0] mem_data_in;
  logic [AW-1:0] mem_in_add;
  logic mem_wr_en, mem_rd_en, mem_chiprd_en;
  logic signed [DW-1:0] mem_chip_data;
  logic line_valid;
  logic signed [DW-1:0] dump_data;
  logic dump_valid;
  logic busy;
  logic [CW-1:0] line_cnt;

  line_mem_loader #(.DW(DW), .MEM_SIZE(MS), .MEM_ADDR(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_data_in(mem_data_in), .mem_in_add(mem_in_add), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_chiprd_en(mem_chiprd_en), .mem_chip_data(mem_chip_data),
    .line_valid(line_valid), .line_ack(line_ack), .dump_req(dump_req),
    .dump_data(dump_data), .dump_valid(dump_valid), .busy(busy), .line_cnt(line_cnt)
  );

  always #5 clk = ~clk;

  // Line memory: drops writes while the wide read is enabled, shares the reset.
  logic signed [DW-1:0] mem [MS];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MS; i++) mem[i] <= '0;
    end else if (mem_wr_en && !mem_rd_en && (int'(mem_in_add) < MS)) begin
      mem[mem_in_add] <= mem_data_in;
    end
  end
  always_comb begin
    mem_chip_data = '0;
    if (int'(mem_in_add) < MS) mem_chip_data = mem[mem_in_add];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int wr_cnt = 0;
  int model_cnt = 0;
  logic [DW*MS-1:0] cur_line = '0;
  logic [DW*MS-1:0] model_mem = '0;

  // Scoreboard queues
  logic [AW-1:0]        wr_addr_q[$];
  logic signed [DW-1:0] wr_data_q[$];
  logic [DW*MS-1:0]     line_q[$];
  int                   line_cyc_q[$];
  logic signed [DW-1:0] exp_dump_q[$];
  int                   dump_cyc_q[$];

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_rd_en", mem_rd_en, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_chiprd_en", mem_chiprd_en, 0);
    chk("rst_dump_valid", dump_valid, 0);
    chk("rst_dump_data", dump_data, 0);
    chk("rst_line_cnt", line_cnt, 0);
    chk("rst_mem_in_add", mem_in_add, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 1);
  endtask

  task automatic send_word(input logic signed [DW-1:0] d);
    int guard;
    @(negedge clk);
    s_valid = 1'b1;
    s_data = d;
    #1;
    guard = 0;
    while (!s_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!s_ready) begin
      chk("sready_timeout", 0, 1);
      s_valid = 1'b0;
      return;
    end
    wr_addr_q.push_back(AW'(wr_cnt));
    wr_data_q.push_back(d);
    cur_line[DW*wr_cnt +: DW] = d;
    wr_cnt++;
    if (wr_cnt == MS) begin
      line_q.push_back(cur_line);
      line_cyc_q.push_back(cyc + 2);
      model_mem = cur_line;
      wr_cnt = 0;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ack_line();
    int guard;
    int hold;
    chk("sready_drain", s_ready, 0);
    guard = 0;
    while (!line_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("line_valid_seen", line_valid, 1);
    hold = $urandom_range(0, 3);
    repeat (hold) begin
      chk("sready_present", s_ready, 0);
      chk("lv_hold", line_valid, 1);
      @(negedge clk);
    end
    chk("sready_present", s_ready, 0);
    line_ack = 1'b1;
    @(posedge clk);
    #1;
    line_ack = 1'b0;
    model_cnt = (model_cnt + 1) % (1 << CW);
    @(negedge clk);
    chk("lv_fall", line_valid, 0);
    chk("rd_fall", mem_rd_en, 0);
    chk("line_cnt", line_cnt, model_cnt);
    chk("busy_idle", busy, 0);
  endtask

  task automatic do_dump();
    @(negedge clk);
    dump_req = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    #1;
    chk("sready_dumpreq", s_ready, 0);
    for (int k = 0; k < MS; k++) begin
      exp_dump_q.push_back($signed(model_mem[DW*k +: DW]));
      dump_cyc_q.push_back(cyc + 2 + k);
    end
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    for (int k = 0; k < MS; k++) begin
      chk("sready_dump", s_ready, 0);
      chk("busy_dump", busy, 1);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    idle(2);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin
    logic lv_prev;
    logic [DW*MS-1:0] el;
    int ec;
    lv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        lv_prev = 1'b0;
      end else begin
        chk("wr_rd_excl", mem_wr_en && mem_rd_en, 0);
        chk("rd_en_eq_lv", mem_rd_en, line_valid);
        if (mem_wr_en) begin
          if (wr_addr_q.size() == 0) chk("wr_unexpected", 1, 0);
          else begin
            chk("wr_addr", mem_in_add, wr_addr_q.pop_front());
            chk("wr_data", mem_data_in, wr_data_q.pop_front());
          end
        end
        if (line_valid && !lv_prev) begin
          if (line_q.size() == 0) chk("line_unexpected", 1, 0);
          else begin
            el = line_q.pop_front();
            ec = line_cyc_q.pop_front();
            chk("line_rise_cyc", cyc, ec);
            for (int i = 0; i < MS; i++) chk("line_word", mem[i], $signed(el[DW*i +: DW]));
          end
        end
        lv_prev = line_valid;
        if (dump_valid) begin
          if (exp_dump_q.size() == 0) chk("dump_unexpected", 1, 0);
          else begin
            chk("dump_data", dump_data, exp_dump_q.pop_front());
            chk("dump_cyc", cyc, dump_cyc_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Line 1..10, back to back
    for (int v = 1; v <= MS; v++) send_word(DW'(v));
    ack_line();

    // Signed line -5..4, back to back
    for (int v = -5; v <= 4; v++) send_word(DW'(v));
    ack_line();

    // Same signed line with one idle cycle between words
    for (int v = -5; v <= 4; v++) begin
      send_word(DW'(v));
      if (v == -3) chk("busy_partial", busy, 1);
      idle(1);
    end
    ack_line();

    // Line 1..10 then dump it
    for (int v = 1; v <= MS; v++) send_word(DW'(v));
    ack_line();
    do_dump();

    // line_ack outside PRESENT is ignored
    @(negedge clk);
    line_ack = 1'b1;
    @(posedge clk);
    #1;
    line_ack = 1'b0;
    @(negedge clk);
    chk("ack_in_fill_cnt", line_cnt, model_cnt);
    chk("ack_in_fill_lv", line_valid, 0);

    // dump_req with a partial line held: stalls the stream, no dump starts
    for (int i = 0; i < 3; i++) send_word(DW'($urandom));
    @(negedge clk);
    dump_req = 1'b1;
    s_valid = 1'b1;
    s_data = DW'($urandom);
    #1;
    chk("sready_dumpreq_partial", s_ready, 0);
    @(posedge clk);
    #1;
    dump_req = 1'b0;
    s_valid = 1'b0;
    for (int i = 3; i < MS; i++) begin
      send_word(DW'($urandom));
      idle($urandom_range(0, 2));
    end
    ack_line();
    do_dump();

    // Reset mid-line after 5 accepts
    for (int i = 0; i < 5; i++) send_word(DW'($urandom));
    idle(2);
    chk("busy_before_reset", busy, 1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    wr_cnt = 0;
    model_cnt = 0;
    cur_line = '0;
    model_mem = '0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Clean line after reset, counter restarts
    for (int i = 0; i < MS; i++) send_word(DW'($urandom));
    ack_line();
    do_dump();

    idle(5);
    chk("wr_q_drained", wr_addr_q.size(), 0);
    chk("line_q_drained", line_q.size(), 0);
    chk("dump_q_drained", exp_dump_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
